// File: rtl/operand_fetch.sv
// ============================================================================
// Module      : operand_fetch
// Description : Reads source operands from the register file, stalls on RAW
//               hazards, and forwards operands to execute.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module operand_fetch #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int CNT_W = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] sr1,
    input  logic [AW-1:0] sr2,
    input  logic          use_sr1,
    input  logic          use_sr2,
    input  logic [AW-1:0] dr,
    input  logic          writes_dr,
    output logic [AW-1:0] rf_sr1,
    output logic [AW-1:0] rf_sr2,
    input  logic [DW-1:0] rf_d1,
    input  logic [DW-1:0] rf_d2,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_dr,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_vsr1,
    output logic [DW-1:0] out_vsr2,
    output logic [AW-1:0] out_dr,
    output logic          out_wdr
);

    localparam int              NREG    = 1 << AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Outstanding-write count per architectural register
    logic [CNT_W-1:0] cnt [NREG];

    logic          wb_hit1;
    logic          wb_hit2;
    logic          wb_hit_dr;
    logic          blocked1;
    logic          blocked2;
    logic          full_stall;
    logic          pipe_free;
    logic          issue;
    logic [DW-1:0] opnd1;
    logic [DW-1:0] opnd2;
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;

    assign rf_sr1 = sr1;
    assign rf_sr2 = sr2;

    assign wb_hit1   = wb_en && (wb_dr == sr1);
    assign wb_hit2   = wb_en && (wb_dr == sr2);
    assign wb_hit_dr = wb_en && (wb_dr == dr);

    // A single outstanding write is harmless when it retires this very cycle
    assign blocked1 = use_sr1 &&
                      ((cnt[sr1] > CNT_ONE) || ((cnt[sr1] == CNT_ONE) && !wb_hit1));
    assign blocked2 = use_sr2 &&
                      ((cnt[sr2] > CNT_ONE) || ((cnt[sr2] == CNT_ONE) && !wb_hit2));

    assign full_stall = writes_dr && (cnt[dr] == CNT_MAX) && !wb_hit_dr;

    assign pipe_free = !out_valid || out_ready;
    assign in_ready  = pipe_free && !blocked1 && !blocked2 && !full_stall;
    assign issue     = in_valid && in_ready;

    assign opnd1 = wb_hit1 ? wb_data : rf_d1;
    assign opnd2 = wb_hit2 ? wb_data : rf_d2;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 0; r < NREG; r++) begin
            inc[r] = issue && writes_dr && (dr == AW'(r));
            dec[r] = wb_en && (wb_dr == AW'(r)) && (cnt[r] != '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (inc[r] && !dec[r]) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (dec[r] && !inc[r]) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

    // Output register: holds while execute back-pressures
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_vsr1  <= '0;
            out_vsr2  <= '0;
            out_dr    <= '0;
            out_wdr   <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_vsr1  <= opnd1;
            out_vsr2  <= opnd2;
            out_dr    <= dr;
            out_wdr   <= writes_dr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module      : tb_operand_fetch
// Description : Directed self-checking bench for operand_fetch.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_operand_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [2:0]  sr1, sr2, dr, rf_sr1, rf_sr2, wb_dr, out_dr;
    logic        use_sr1, use_sr2, writes_dr, wb_en, out_valid, out_ready, out_wdr;
    logic [15:0] rf_d1, rf_d2, wb_data, out_vsr1, out_vsr2;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    // Register file stand-in: register r reads as 16'hA000 + r
    assign rf_d1 = {13'h1400, rf_sr1};
    assign rf_d2 = {13'h1400, rf_sr2};

    operand_fetch dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sr1(sr1), .sr2(sr2), .use_sr1(use_sr1), .use_sr2(use_sr2),
        .dr(dr), .writes_dr(writes_dr), .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
        .rf_d1(rf_d1), .rf_d2(rf_d2), .wb_en(wb_en), .wb_dr(wb_dr),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_vsr1(out_vsr1), .out_vsr2(out_vsr2), .out_dr(out_dr), .out_wdr(out_wdr)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; sr1 = 0; sr2 = 0; use_sr1 = 0; use_sr2 = 0;
        dr = 0; writes_dr = 0; wb_en = 0; wb_dr = 0; wb_data = 0; out_ready = 1;
    endtask

    task automatic instr(input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                         input logic u2, input logic [2:0] d, input logic w);
        in_valid = 1; sr1 = s1; use_sr1 = u1; sr2 = s2; use_sr2 = u2;
        dr = d; writes_dr = w;
    endtask

    task automatic test_reset();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom); sr1 = 3'($urandom); sr2 = 3'($urandom);
            use_sr1 = 1'($urandom); use_sr2 = 1'($urandom); dr = 3'($urandom);
            writes_dr = 1'($urandom); wb_en = 1'($urandom); wb_dr = 3'($urandom);
            wb_data = 16'($urandom); out_ready = 1'($urandom);
            step();
            total++;
            if (out_valid !== 1'b0 || out_vsr1 !== 16'h0 || out_vsr2 !== 16'h0 ||
                out_dr !== 3'h0 || out_wdr !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: valid=%b v1=%h v2=%h dr=%h wdr=%b want all 0",
                         out_valid, out_vsr1, out_vsr2, out_dr, out_wdr);
            end
        end
        idle();
        reset = 1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        // Every register must read without stalling after reset
        for (int r = 0; r < 8; r++) begin
            instr(3'(r), 1, 3'(7 - r), 1, 3'd0, 0);
            #1;
            total++;
            if (in_ready !== 1'b1 || rf_sr1 !== 3'(r)) begin
                bad++;
                $display("FAIL reset_cnt_r%0d: in_ready=%b rf_sr1=%0d want 1/%0d",
                         r, in_ready, rf_sr1, r);
            end
            step();
            total++;
            if (out_valid !== 1'b1 || out_vsr1 !== 16'hA000 + 16'(r) ||
                out_vsr2 !== 16'hA000 + 16'(7 - r)) begin
                bad++;
                $display("FAIL reset_read_r%0d: valid=%b v1=%h v2=%h want 1 %h %h", r,
                         out_valid, out_vsr1, out_vsr2, 16'hA000 + 16'(r), 16'hA000 + 16'(7 - r));
            end
        end
        idle();
        step();
    endtask

    task automatic test_raw();
        instr(3'd0, 0, 3'd0, 0, 3'd3, 1);
        step();
        total++;
        if (out_valid !== 1'b1 || out_dr !== 3'd3 || out_wdr !== 1'b1) begin
            bad++;
            $display("FAIL raw_writer: valid=%b dr=%0d wdr=%b want 1 3 1", out_valid, out_dr, out_wdr);
        end
        instr(3'd3, 1, 3'd0, 0, 3'd0, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL raw_stall_%0d: in_ready=%b want 0", i, in_ready);
            end
            step();
        end
        wb_en = 1; wb_dr = 3'd3; wb_data = 16'h8001;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL raw_release: in_ready=%b want 1", in_ready);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_vsr1 !== 16'h8001) begin
            bad++;
            $display("FAIL raw_bypass: valid=%b v1=%h want 1 8001", out_valid, out_vsr1);
        end
        wb_en = 0;
        instr(3'd3, 1, 3'd0, 0, 3'd0, 0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL raw_cleared: in_ready=%b want 1", in_ready);
        end
        idle();
        step();
    endtask

    task automatic test_backpressure();
        instr(3'd1, 1, 3'd2, 1, 3'd4, 0);
        step();
        out_ready = 0;
        instr(3'd6, 1, 3'd0, 0, 3'd0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vsr1 !== 16'hA001 ||
                out_vsr2 !== 16'hA002 || out_dr !== 3'd4) begin
                bad++;
                $display("FAIL bp_hold_%0d: rdy=%b valid=%b v1=%h v2=%h dr=%0d want 0 1 a001 a002 4",
                         i, in_ready, out_valid, out_vsr1, out_vsr2, out_dr);
            end
            step();
        end
        out_ready = 1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b want 1", in_ready);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_vsr1 !== 16'hA006) begin
            bad++;
            $display("FAIL bp_next: valid=%b v1=%h want 1 a006", out_valid, out_vsr1);
        end
        idle();
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            instr(3'd0, 0, 3'd0, 0, 3'd5, 1);
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL sat_fill_%0d: in_ready=%b want 1", i, in_ready);
            end
            step();
        end
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL sat_full: in_ready=%b want 0", in_ready);
        end
        wb_en = 1; wb_dr = 3'd5; wb_data = 16'h1234;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL sat_wb_release: in_ready=%b want 1", in_ready);
        end
        step();
        wb_en = 0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL sat_still_full: in_ready=%b want 0", in_ready);
        end
        in_valid = 0;
        wb_en = 1; wb_dr = 3'd5;
        step();
        step();
        wb_en = 0;
        instr(3'd5, 1, 3'd0, 0, 3'd0, 0);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL sat_one_left: in_ready=%b want 0", in_ready);
        end
        wb_en = 1; wb_dr = 3'd5; wb_data = 16'h5555;
        step();
        total++;
        if (out_valid !== 1'b1 || out_vsr1 !== 16'h5555) begin
            bad++;
            $display("FAIL sat_last_bypass: valid=%b v1=%h want 1 5555", out_valid, out_vsr1);
        end
        idle();
        step();
    endtask

    task automatic test_inc_dec();
        instr(3'd0, 0, 3'd0, 0, 3'd2, 1);
        step();
        wb_en = 1; wb_dr = 3'd2; wb_data = 16'h0BAD;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL incdec_issue: in_ready=%b want 1", in_ready);
        end
        step();
        wb_en = 0;
        instr(3'd0, 0, 3'd2, 1, 3'd0, 0);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL incdec_stall: in_ready=%b want 0", in_ready);
        end
        wb_en = 1; wb_dr = 3'd2; wb_data = 16'hC0DE;
        step();
        total++;
        if (out_valid !== 1'b1 || out_vsr2 !== 16'hC0DE) begin
            bad++;
            $display("FAIL incdec_bypass: valid=%b v2=%h want 1 c0de", out_valid, out_vsr2);
        end
        idle();
        step();
    endtask

    task automatic test_reset_mid();
        instr(3'd0, 0, 3'd0, 0, 3'd1, 1);
        step();
        instr(3'd0, 0, 3'd0, 0, 3'd6, 1);
        step();
        idle();
        out_ready = 0;
        reset = 0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_dr !== 3'd0 || out_wdr !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async: valid=%b dr=%0d wdr=%b want 0 0 0", out_valid, out_dr, out_wdr);
        end
        #2;
        reset = 1;
        out_ready = 1;
        step();
        wb_en = 1; wb_dr = 3'd1; wb_data = 16'hDEAD;
        step();
        wb_en = 0;
        instr(3'd1, 1, 3'd6, 1, 3'd0, 0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_no_stall: in_ready=%b want 1", in_ready);
        end
        step();
        total++;
        if (out_vsr1 !== 16'hA001 || out_vsr2 !== 16'hA006) begin
            bad++;
            $display("FAIL midrst_read: v1=%h v2=%h want a001 a006", out_vsr1, out_vsr2);
        end
        idle();
        step();
    endtask

    initial begin
        idle();
        reset = 0;
        test_reset();
        test_raw();
        test_backpressure();
        test_saturation();
        test_inc_dec();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
